// File: rtl/sd_block_seq_if.sv
// Bus between the SD block-test sequencer and its init/write/read engines,
// grouping requests, completions, received bytes, SPI pairs and run status.
interface sd_block_seq_if;
  logic        start;
  logic        init_done;
  logic        wr_req;
  logic [31:0] wr_sec;
  logic        wr_done;
  logic        rd_req;
  logic [31:0] rd_sec;
  logic        rd_done;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        init_cs;
  logic        init_mosi;
  logic        wr_cs;
  logic        wr_mosi;
  logic        rd_cs;
  logic        rd_mosi;
  logic        SD_cs;
  logic        SD_datain;
  logic        busy;
  logic        pass;
  logic        fail;
  logic [15:0] err_cnt;

  modport master (
    input  start, init_done, wr_done, rd_done, rd_data, rd_valid,
    input  init_cs, init_mosi, wr_cs, wr_mosi, rd_cs, rd_mosi,
    output wr_req, wr_sec, rd_req, rd_sec, SD_cs, SD_datain,
    output busy, pass, fail, err_cnt
  );

  modport slave (
    output start, init_done, wr_done, rd_done, rd_data, rd_valid,
    output init_cs, init_mosi, wr_cs, wr_mosi, rd_cs, rd_mosi,
    input  wr_req, wr_sec, rd_req, rd_sec, SD_cs, SD_datain,
    input  busy, pass, fail, err_cnt
  );
endinterface

// File: rtl/sd_block_seq.sv
// SD card block test sequencer: writes SEC_COUNT consecutive sectors, reads
// them back, checks every byte against a pattern and reports pass/fail.
module sd_block_seq #(
  parameter int          SEC_COUNT    = 4,
  parameter logic [31:0] START_SEC    = 32'd0,
  parameter int          PATTERN_MODE = 0,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd2_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  sd_block_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_WRITE = 3'd2,
    S_READ  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [15:0] LAST_K     = 16'(SEC_COUNT - 1);
  localparam logic [23:0] TMO_LAST   = TIMEOUT_CYC - 24'd1;
  localparam logic [9:0]  BLOCK_LEN  = 10'd512;

  state_t      state_q, state_d;
  logic [15:0] k_q, k_d;
  logic [9:0]  idx_q, idx_d;
  logic [15:0] err_q, err_d;
  logic [31:0] wr_sec_q, wr_sec_d;
  logic [31:0] rd_sec_q, rd_sec_d;
  logic        wr_req_q, wr_req_d;
  logic        rd_req_q, rd_req_d;
  logic        pend_q, pend_d;
  logic [23:0] tmo_q, tmo_d;
  logic        busy_q, busy_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        progress;
  logic [15:0] err_acc;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [9:0] idx, input logic [31:0] sec);
    return (PATTERN_MODE == 1) ? idx[7:0] + sec[7:0] : idx[7:0];
  endfunction

  function automatic logic [31:0] sec_addr(input logic [15:0] k);
    return START_SEC + {16'd0, k};
  endfunction

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      idx_q    <= '0;
      err_q    <= '0;
      wr_sec_q <= '0;
      rd_sec_q <= '0;
      wr_req_q <= 1'b0;
      rd_req_q <= 1'b0;
      pend_q   <= 1'b0;
      tmo_q    <= '0;
      busy_q   <= 1'b0;
      pass_q   <= 1'b0;
      fail_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      wr_sec_q <= wr_sec_d;
      rd_sec_q <= rd_sec_d;
      wr_req_q <= wr_req_d;
      rd_req_q <= rd_req_d;
      pend_q   <= pend_d;
      tmo_q    <= tmo_d;
      busy_q   <= busy_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
    end
  end

  // Next-state and next-value logic
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    idx_d    = idx_q;
    err_d    = err_q;
    wr_sec_d = wr_sec_q;
    rd_sec_d = rd_sec_q;
    wr_req_d = 1'b0;
    rd_req_d = 1'b0;
    pend_d   = pend_q;
    busy_d   = busy_q;
    pass_d   = pass_q;
    fail_d   = fail_q;
    tmo_d    = tmo_q + 24'd1;
    progress = 1'b0;
    err_acc  = err_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        tmo_d = '0;
        if (bus.start) begin
          state_d = S_INIT;
          busy_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          err_d   = '0;
          k_d     = '0;
          idx_d   = '0;
          pend_d  = 1'b0;
        end
      end

      S_INIT: begin
        if (bus.init_done) begin
          state_d  = S_WRITE;
          wr_sec_d = sec_addr(k_q);
          pend_d   = 1'b1;
        end
      end

      // The request pulse trails the address by one cycle so the engine
      // always samples a settled sector number.
      S_WRITE: begin
        if (pend_q) begin
          wr_req_d = 1'b1;
          pend_d   = 1'b0;
        end
        if (bus.wr_done) begin
          progress = 1'b1;
          pend_d   = 1'b1;
          if (k_q < LAST_K) begin
            k_d      = k_q + 16'd1;
            wr_sec_d = sec_addr(k_q + 16'd1);
          end else begin
            k_d      = '0;
            state_d  = S_READ;
            rd_sec_d = START_SEC;
          end
        end
      end

      S_READ: begin
        if (pend_q) begin
          rd_req_d = 1'b1;
          pend_d   = 1'b0;
        end
        if (bus.rd_valid) begin
          progress = 1'b1;
          if (idx_q == BLOCK_LEN) begin
            err_acc = sat_inc(err_acc);
          end else begin
            if (bus.rd_data != exp_byte(idx_q, rd_sec_q))
              err_acc = sat_inc(err_acc);
            idx_d = idx_q + 10'd1;
          end
        end
        // idx_d already includes a byte arriving alongside rd_done
        if (bus.rd_done) begin
          progress = 1'b1;
          if (idx_d != BLOCK_LEN)
            err_acc = sat_inc(err_acc);
          idx_d = '0;
          if (k_q < LAST_K) begin
            k_d      = k_q + 16'd1;
            rd_sec_d = sec_addr(k_q + 16'd1);
            pend_d   = 1'b1;
          end else begin
            k_d     = '0;
            state_d = S_DONE;
            busy_d  = 1'b0;
            pass_d  = (err_acc == 16'd0);
            fail_d  = (err_acc != 16'd0);
          end
        end
        err_d = err_acc;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (progress)
      tmo_d = '0;

    if ((state_q inside {S_INIT, S_WRITE, S_READ}) && !progress &&
        (state_d == state_q) && (tmo_q == TMO_LAST)) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      pass_d  = 1'b0;
      fail_d  = 1'b1;
      pend_d  = 1'b0;
      k_d     = '0;
      idx_d   = '0;
    end

    if (state_d != state_q)
      tmo_d = '0;
  end

  // SPI pair mux follows the registered state only
  always_comb begin
    bus.SD_cs     = 1'b1;
    bus.SD_datain = 1'b1;
    case (state_q)
      S_INIT: begin
        bus.SD_cs     = bus.init_cs;
        bus.SD_datain = bus.init_mosi;
      end
      S_WRITE: begin
        bus.SD_cs     = bus.wr_cs;
        bus.SD_datain = bus.wr_mosi;
      end
      S_READ: begin
        bus.SD_cs     = bus.rd_cs;
        bus.SD_datain = bus.rd_mosi;
      end
      default: begin
        bus.SD_cs     = 1'b1;
        bus.SD_datain = 1'b1;
      end
    endcase
  end

  assign bus.wr_req  = wr_req_q;
  assign bus.wr_sec  = wr_sec_q;
  assign bus.rd_req  = rd_req_q;
  assign bus.rd_sec  = rd_sec_q;
  assign bus.busy    = busy_q;
  assign bus.pass    = pass_q;
  assign bus.fail    = fail_q;
  assign bus.err_cnt = err_q;

endmodule

// File: tb/tb_sd_block_seq.sv
// Randomized bench for sd_block_seq: three instances (pattern mode 0, mode 1,
// wrapping start sector) driven by a shared engine model and scoreboard.
module tb_sd_block_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start_v;
  logic       init_done, wr_done, rd_done, rd_valid;
  logic [7:0] rd_data;
  logic       init_cs, init_mosi, wr_cs, wr_mosi, rd_cs, rd_mosi;

  logic        wr_req_v [3];
  logic        rd_req_v [3];
  logic        sdcs_v   [3];
  logic        sddi_v   [3];
  logic        busy_v   [3];
  logic        pass_v   [3];
  logic        fail_v   [3];
  logic [31:0] wr_sec_v [3];
  logic [31:0] rd_sec_v [3];
  logic [15:0] err_v    [3];

  int n_chk  = 0;
  int n_pass = 0;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    sd_block_seq_if bus ();
    assign bus.start     = start_v[g];
    assign bus.init_done = init_done;
    assign bus.wr_done   = wr_done;
    assign bus.rd_done   = rd_done;
    assign bus.rd_data   = rd_data;
    assign bus.rd_valid  = rd_valid;
    assign bus.init_cs   = init_cs;
    assign bus.init_mosi = init_mosi;
    assign bus.wr_cs     = wr_cs;
    assign bus.wr_mosi   = wr_mosi;
    assign bus.rd_cs     = rd_cs;
    assign bus.rd_mosi   = rd_mosi;
    assign wr_req_v[g]   = bus.wr_req;
    assign rd_req_v[g]   = bus.rd_req;
    assign sdcs_v[g]     = bus.SD_cs;
    assign sddi_v[g]     = bus.SD_datain;
    assign busy_v[g]     = bus.busy;
    assign pass_v[g]     = bus.pass;
    assign fail_v[g]     = bus.fail;
    assign wr_sec_v[g]   = bus.wr_sec;
    assign rd_sec_v[g]   = bus.rd_sec;
    assign err_v[g]      = bus.err_cnt;

    sd_block_seq #(
      .SEC_COUNT   (2),
      .START_SEC   ((g == 2) ? 32'hFFFF_FFFF : 32'd0),
      .PATTERN_MODE((g == 1) ? 1 : 0),
      .TIMEOUT_CYC (24'd1000)
    ) u_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: sector numbering, byte pattern and error arithmetic
  function automatic logic [31:0] ref_start(input int s);
    return (s == 2) ? 32'hFFFF_FFFF : 32'd0;
  endfunction

  function automatic logic [7:0] ref_byte(input int s, input int i, input logic [31:0] sec);
    logic [7:0] b;
    b = 8'(i);
    return (s == 1) ? b + sec[7:0] : b;
  endfunction

  function automatic int ref_errs(input int n, input int cpos);
    int e;
    e = 0;
    if (cpos >= 0 && cpos < n && cpos < 512) e++;
    if (n > 512) e += n - 512;
    if (n < 512) e++;
    return e;
  endfunction

  task automatic wait_req(input int s, input bit rd, inout int lat);
    int b;
    b = 0;
    while (((rd ? rd_req_v[s] : wr_req_v[s]) !== 1'b1) && b < 3000) begin
      @(negedge clk);
      b++;
      lat++;
    end
    if (b >= 3000) chk(rd ? "rd_req_wait" : "wr_req_wait", 32'd0, 32'd1);
  endtask

  task automatic reset_checks(input int s, input string tag);
    chk({tag, "_busy"}, busy_v[s], 1'b0);
    chk({tag, "_passfail"}, {pass_v[s], fail_v[s]}, 2'b00);
    chk({tag, "_err"}, err_v[s], 16'd0);
    chk({tag, "_reqs"}, {wr_req_v[s], rd_req_v[s]}, 2'b00);
    chk({tag, "_wr_sec"}, wr_sec_v[s], 32'd0);
    chk({tag, "_rd_sec"}, rd_sec_v[s], 32'd0);
    chk({tag, "_spi"}, {sdcs_v[s], sddi_v[s]}, 2'b11);
  endtask

  task automatic run(input int s, input int n0, input int n1, input int c0, input int c1,
                     input bit init_hi, input int abort_i);
    int n [2];
    int c [2];
    int lat, exp_err, gap;
    bit same;
    logic [31:0] sec;
    n[0] = n0; n[1] = n1; c[0] = c0; c[1] = c1;
    exp_err = ref_errs(n0, c0) + ref_errs(n1, c1);

    @(negedge clk);
    init_done  = init_hi;
    start_v[s] = 1'b1;
    @(negedge clk);
    chk("busy_on", busy_v[s], 1'b1);
    chk("init_spi", {sdcs_v[s], sddi_v[s]}, 2'b01);
    chk("err_clr", err_v[s], 16'd0);
    chk("pf_clr", {pass_v[s], fail_v[s]}, 2'b00);
    @(negedge clk);
    start_v[s] = 1'b0;
    lat = 1;
    if (!init_hi) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      init_done = 1'b1;
    end

    for (int k = 0; k < 2; k++) begin
      wait_req(s, 1'b0, lat);
      if (k == 0 && init_hi) chk("restart_lat", lat, 32'd2);
      chk("wr_sec", wr_sec_v[s], ref_start(s) + 32'(k));
      chk("wr_spi", {sdcs_v[s], sddi_v[s]}, 2'b10);
      @(negedge clk);
      chk("wr_req_pulse", wr_req_v[s], 1'b0);
      repeat ($urandom_range(0, 4)) @(negedge clk);
      wr_done = 1'b1;
      @(negedge clk);
      wr_done = 1'b0;
    end

    for (int k = 0; k < 2; k++) begin
      lat = 0;
      wait_req(s, 1'b1, lat);
      sec = ref_start(s) + 32'(k);
      chk("rd_sec", rd_sec_v[s], sec);
      chk("rd_spi", {sdcs_v[s], sddi_v[s]}, 2'b00);
      @(negedge clk);
      chk("rd_req_pulse", rd_req_v[s], 1'b0);
      same = 1'($urandom_range(0, 1));
      for (int i = 0; i < n[k]; i++) begin
        if (abort_i >= 0 && k == 1 && i == abort_i) begin
          #2 rst_n = 1'b0;
          #1 reset_checks(s, "async_rst");
          rd_valid  = 1'b0;
          init_done = 1'b0;
          @(negedge clk);
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        rd_valid = 1'b1;
        rd_data  = (i < 512) ? ref_byte(s, i, sec) : 8'($urandom);
        if (i == c[k]) rd_data = rd_data ^ 8'h5A;
        if (same && i == n[k] - 1) rd_done = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        rd_done  = 1'b0;
        gap = $urandom_range(0, 1);
        repeat (gap) @(negedge clk);
      end
      if (!same) begin
        rd_done = 1'b1;
        @(negedge clk);
        rd_done = 1'b0;
      end
    end

    lat = 0;
    while (busy_v[s] && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("busy_off", busy_v[s], 1'b0);
    chk("err_cnt", err_v[s], 32'(exp_err));
    chk("pass", pass_v[s], exp_err == 0);
    chk("fail", fail_v[s], exp_err != 0);
    chk("done_spi", {sdcs_v[s], sddi_v[s]}, 2'b11);
    repeat (3) @(negedge clk);
    chk("result_hold", {pass_v[s], fail_v[s]}, {exp_err == 0, exp_err != 0});
  endtask

  task automatic run_timeout();
    int j;
    @(negedge clk);
    init_done  = 1'b0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    chk("tmo_busy", busy_v[0], 1'b1);
    j = 0;
    while (busy_v[0] && j < 3000) begin
      @(negedge clk);
      j++;
    end
    chk("tmo_cycles", j, 32'd1000);
    chk("tmo_fail", {pass_v[0], fail_v[0]}, 2'b01);
    chk("tmo_err", err_v[0], 16'd0);
    chk("tmo_spi", sdcs_v[0], 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation exceeded its time limit");
    $fatal(1);
  end

  initial begin
    int s, n0, n1, c0, c1;
    rst_n = 1'b0; start_v = 3'b000;
    init_done = 1'b0; wr_done = 1'b0; rd_done = 1'b0; rd_valid = 1'b0; rd_data = 8'h00;
    init_cs = 1'b0; init_mosi = 1'b1;
    wr_cs   = 1'b1; wr_mosi   = 1'b0;
    rd_cs   = 1'b0; rd_mosi   = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) reset_checks(d, "reset");
    rst_n = 1'b1;

    run(0, 512, 512, -1, -1, 1'b0, -1);
    run(1, 512, 512, -1, 5, 1'b0, -1);
    run(1, 512, 512, -1, -1, 1'b1, -1);
    run(0, 511, 512, -1, -1, 1'b0, -1);
    run(0, 512, 513, -1, -1, 1'b0, -1);
    run(2, 512, 512, -1, -1, 1'b0, -1);
    run_timeout();
    run(2, 512, 512, 3, -1, 1'b0, 200);
    run(2, 512, 512, -1, -1, 1'b0, -1);

    for (int r = 0; r < 4; r++) begin
      s  = $urandom_range(0, 2);
      n0 = 511 + $urandom_range(0, 2);
      n1 = 511 + $urandom_range(0, 2);
      c0 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 511) : -1;
      c1 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 511) : -1;
      run(s, n0, n1, c0, c1, 1'($urandom_range(0, 1)), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sd_block_seq.md
SD_BLOCK_SEQ -- requirements
Module: sd_block_seq

Interface
REQ-001 Parameter SEC_COUNT, default 4: number of consecutive sectors written then read back, legal range 1..65535.
REQ-002 Parameter START_SEC, default 32'd0: first sector address.
REQ-003 Parameter PATTERN_MODE, default 0: expected-data mode; 0 = idx[7:0], 1 = idx[7:0] + sec[7:0] mod 256.
REQ-004 Parameter TIMEOUT_CYC, default 24'd2_000_000: maximum cycles without progress in any active state.
REQ-005 clk  input  1  SD-domain clock; one clock, all logic on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous, active-low.
REQ-007 start  input  1  level; starts a run when sampled high in IDLE or DONE (tie high for auto-start).
REQ-008 init_done  input  1  init engine finished (level).
REQ-009 wr_req  output  1  one-cycle write-block request pulse.
REQ-010 wr_sec  output  32  sector for the current write.
REQ-011 wr_done  input  1  write engine block complete (pulse).
REQ-012 rd_req  output  1  one-cycle read-block request pulse.
REQ-013 rd_sec  output  32  sector for the current read.
REQ-014 rd_done  input  1  read engine block complete (pulse).
REQ-015 rd_data  input  8  read byte, valid with rd_valid.
REQ-016 rd_valid  input  1  one-cycle strobe per received byte.
REQ-017 init_cs, init_mosi  input  1 each  init engine SPI CS / MOSI.
REQ-018 wr_cs, wr_mosi  input  1 each  write engine SPI CS / MOSI.
REQ-019 rd_cs, rd_mosi  input  1 each  read engine SPI CS / MOSI.
REQ-020 SD_cs  output  1  muxed card chip select.
REQ-021 SD_datain  output  1  muxed card MOSI.
REQ-022 busy  output  1  run in progress.
REQ-023 pass  output  1  last run completed with err_cnt == 0.
REQ-024 fail  output  1  last run completed with errors or timeout.
REQ-025 err_cnt  output  16  mismatch/length error count, saturating at 16'hFFFF.

Function
REQ-026 States IDLE, INIT, WRITE, READ, DONE; IDLE/DONE + start -> INIT: busy=1; pass, fail, err_cnt, sector index k cleared.
REQ-027 INIT: init_done high -> WRITE next cycle; already-high init_done on entry (restart) transitions after one cycle.
REQ-028 WRITE entry and each new sector: wr_sec = START_SEC + k (32-bit wrap), wr_req high exactly one cycle after wr_sec is stable.
REQ-029 WRITE + wr_done: k < SEC_COUNT-1 -> k+1, next wr_req; else k=0, -> READ with rd_sec = START_SEC, one rd_req pulse.
REQ-030 READ: byte index idx (10 bit) increments per rd_valid; rd_data != expected(idx, rd_sec) -> err_cnt+1.
REQ-031 rd_valid with idx already 512: err_cnt+1, idx holds, no compare.
REQ-032 rd_done: idx != 512 (counting a same-cycle rd_valid) -> err_cnt+1; idx cleared; next sector as REQ-029 or -> DONE after last; up to 2 increments per cycle allowed.
REQ-033 DONE: busy=0; pass=1 if err_cnt==0 else fail=1; held until next start.
REQ-034 Timeout counter cleared on state entry, wr_done, rd_done, rd_valid; reaching TIMEOUT_CYC-1 -> DONE with fail=1, pass=0, err_cnt unchanged.
REQ-035 SPI mux, combinational on registered state: INIT -> init pair, WRITE -> wr pair, READ -> rd pair, IDLE/DONE -> SD_cs=1, SD_datain=1.
REQ-036 start while busy ignored; wr_done/rd_done/rd_valid outside their own state ignored.

Reset
REQ-037 rst_n low at any time, including mid-block: state=IDLE, wr_req=rd_req=0, wr_sec=rd_sec=0, SD_cs=SD_datain=1, busy=pass=fail=0, err_cnt=0, k=idx=0.

Verification
REQ-038 SEC_COUNT=2, mode 0, correct engine model -> wr_sec 0,1 then rd_sec 0,1, one req pulse each, pass=1, err_cnt=0.
REQ-039 Byte 5 of sector 1 corrupted, mode 1 -> fail=1, err_cnt=1; correct mode-1 data (byte i = i+1) -> pass.
REQ-040 rd_done after 511 bytes -> err_cnt=1; 513 bytes -> err_cnt=1 (extra byte).
REQ-041 init_done never high, TIMEOUT_CYC=1000 -> DONE 1000 cycles after INIT entry, fail=1, err_cnt=0, SD_cs=1.
REQ-042 rst_n low mid-READ -> reset values per REQ-037 asynchronously; start -> full rerun passes.
REQ-043 START_SEC=32'hFFFF_FFFF, SEC_COUNT=2 -> wr_sec FFFF_FFFF then 0000_0000, same for rd_sec.
